// File: rtl/alu_cond_stage.sv
// alu_cond_stage: condition-evaluating, flag-updating output stage for ALU operations.
// Optional COND_STAGE_SKID_EN adds a one-entry skid buffer with a registered in_ready.
module alu_cond_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  cond,
    input  logic [1:0]  flag_write,
    input  logic        reg_write_in,
    input  logic        mem_write_in,
    input  logic        pc_src_in,
    input  logic [3:0]  rd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_rd,
    output logic        reg_write,
    output logic        mem_write,
    output logic        pc_src,
    output logic [3:0]  flags,
    output logic [15:0] squash_count
);
    logic [38:0] out_q, out_d, op;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] squash_q, squash_d;
    logic [15:0] cond_tbl;
    logic        n, z, c, v, pass, accept, out_free;

    assign {n, z, c, v} = flags_q;
    // Indexed by cond: bit k is the pass result for condition code k.
    assign cond_tbl = {1'b0, 1'b1, z | (n != v), !z & (n == v), n != v, n == v, !c | z, c & !z,
                       !v, v, !n, n, !c, c, !z, z};
    assign pass     = cond_tbl[cond];
    assign op       = {alu_result, rd_in, {reg_write_in, mem_write_in, pc_src_in} & {3{pass}}};
    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        flags_d  = (accept && pass) ? {flag_write[1] ? alu_flags[3:2] : flags_q[3:2],
                                       flag_write[0] ? alu_flags[1:0] : flags_q[1:0]} : flags_q;
        squash_d = (accept && !pass && squash_q != 16'hFFFF) ? squash_q + 16'd1 : squash_q;
    end

`ifdef COND_STAGE_SKID_EN
    logic [38:0] skid_q, skid_d;
    logic        skid_full_q, skid_full_d;

    assign in_ready = !skid_full_q;

    // in_ready is low whenever the skid is full, so a drain never races a new accept into it.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (out_free) begin
            out_valid_d = skid_full_q || accept;
            out_d       = skid_full_q ? skid_q : (accept ? op : out_q);
            skid_full_d = 1'b0;
        end else if (accept) begin
            skid_d      = op;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    assign in_ready = out_free;

    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_d       = accept ? op : out_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            squash_q    <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            squash_q    <= squash_d;
        end
    end

    assign {out_result, out_rd, reg_write, mem_write, pc_src} = out_q;
    assign out_valid    = out_valid_q;
    assign flags        = flags_q;
    assign squash_count = squash_q;
endmodule

// File: tb/tb_alu_cond_stage.sv
// tb_alu_cond_stage: directed plus randomized checks of alu_cond_stage against a queue-based model.
module tb_alu_cond_stage;
`ifdef COND_STAGE_SKID_EN
    localparam int DEPTH = 2;
    localparam bit SKID  = 1'b1;
`else
    localparam int DEPTH = 1;
    localparam bit SKID  = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic        pc;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] alu_result = '0, out_result;
    logic [3:0]  alu_flags = '0, cond = '0, rd_in = '0, out_rd, flags;
    logic [1:0]  flag_write = '0;
    logic        reg_write_in = 1'b0, mem_write_in = 1'b0, pc_src_in = 1'b0;
    logic        reg_write, mem_write, pc_src;
    logic [15:0] squash_count;

    int          n_checks = 0, n_pass = 0;
    op_t         q[$];
    logic [3:0]  m_flags = '0;
    logic [15:0] m_squash = '0;

    alu_cond_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .cond(cond), .flag_write(flag_write),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .pc_src_in(pc_src_in),
        .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
        .flags(flags), .squash_count(squash_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [38:0] got, input logic [38:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_op(input logic [3:0] cc, input logic [1:0] fw, input logic [3:0] af,
                          input logic rw, input logic mw, input logic pc);
        in_valid     = 1'b1;
        cond         = cc;
        flag_write   = fw;
        alu_flags    = af;
        reg_write_in = rw;
        mem_write_in = mw;
        pc_src_in    = pc;
        alu_result   = $urandom;
        rd_in        = 4'($urandom);
    endtask

    // One clock: check the DUT against the model mid-cycle, then advance the model over the edge.
    task automatic cycle();
        op_t  e;
        logic exp_rdy, acc, drn, ok;
        @(negedge clk);
        exp_rdy = SKID ? (q.size() < DEPTH) : (q.size() == 0 || out_ready);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0)
            check("out_op", {out_result, out_rd, reg_write, mem_write, pc_src}, q[0]);
        check("flags", flags, m_flags);
        check("squash", squash_count, m_squash);
        acc = !reset && in_valid && exp_rdy;
        drn = q.size() != 0 && out_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            m_flags  = '0;
            m_squash = '0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                ok   = cond_ok(cond, m_flags);
                e.res = alu_result;
                e.rd  = rd_in;
                e.rw  = reg_write_in && ok;
                e.mw  = mem_write_in && ok;
                e.pc  = pc_src_in && ok;
                q.push_back(e);
                if (ok) begin
                    if (flag_write[1]) m_flags[3:2] = alu_flags[3:2];
                    if (flag_write[0]) m_flags[1:0] = alu_flags[1:0];
                end else if (m_squash != 16'hFFFF) begin
                    m_squash++;
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_rd", out_rd, 0);
        check("rst_side", {reg_write, mem_write, pc_src}, 0);
        check("rst_flags", flags, 0);
        check("rst_squash", squash_count, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();

        set_op(4'hE, 2'b11, 4'b0110, 1'b1, 1'b0, 1'b0);
        cycle();
        check("basic_valid", out_valid, 1);
        check("basic_rw", reg_write, 1);
        check("basic_flags", flags, 4'b0110);

        set_op(4'hE, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0);
        cycle();
        set_op(4'h1, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
        cycle();
        check("ne_rw", reg_write, 0);
        check("ne_mw", mem_write, 0);
        check("ne_flags", flags, 4'b0100);
        check("ne_squash", squash_count, 1);

        set_op(4'hE, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
        cycle();
        set_op(4'hB, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
        cycle();
        check("lt_rw", reg_write, 1);

        out_ready = 1'b0;
        repeat (3) begin
            set_op(4'hE, 2'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b0);
            cycle();
        end
        check("stall_rdy", in_ready, 0);
        check("stall_depth", q.size(), DEPTH);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("drained", q.size(), 0);

        set_op(4'hE, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_flags", flags, 0);
        check("rst_mid_squash", squash_count, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();

        repeat (3000) begin
            reset = ($urandom_range(0, 299) == 0);
            set_op(4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (65535) begin
            set_op(4'hF, 2'b11, 4'($urandom), 1'b1, 1'b1, 1'b1);
            cycle();
        end
        check("sat_full", squash_count, 16'hFFFF);
        set_op(4'hF, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1);
        cycle();
        check("sat_hold", squash_count, 16'hFFFF);
        in_valid = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
